// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-ported register file.
//   RF_DATA_WIDTH / RF_ADDR_WIDTH / RF_DEPTH : default geometry
//   rf_state_e : clear-sequencer states
//   rf_word_t  : one register at the default width
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 128;
  localparam int RF_ADDR_WIDTH = 7;
  localparam int RF_DEPTH      = 128;

  typedef enum logic {IDLE, CLEAR} rf_state_e;

  typedef logic [RF_DATA_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: combinational write-port matcher.
// Compares one target address against every enabled write port and reports
// whether any port hits it and which one wins (highest index).
// Used once per storage row (write resolution) and once per read port
// (same-cycle forwarding source).
//   addr    in  target address
//   wr_en   in  per-port write enable
//   wr_addr in  packed write addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   hit     out some enabled port targets addr
//   sel     out index of the winning port (valid when hit)
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int NUM_WR     = 2,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int SELW       = 1
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  output logic                         hit,
  output logic [SELW-1:0]              sel
);

  // Ascending scan: a later (higher) matching port overrides earlier ones.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
        hit = 1'b1;
        sel = SELW'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a hardware clear sequencer.
// NUM_RD registered (1-cycle) read ports, NUM_WR write ports with the highest
// port index winning on address collisions. After reset, or on clr_req in
// IDLE, the sequencer writes zero to one row per cycle (DEPTH cycles total);
// while it runs writes are ignored and read outputs are forced to zero.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to a read of
// the same address; without it such a read returns the old contents.
//   clk, rst_n        clock, async active-low reset
//   clr_req / busy    clear request (IDLE only) / sequencer running
//   wr_en/addr/data   packed write ports
//   rd_en/addr        packed read requests
//   rd_data/rd_valid  registered read results
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_req,
  output logic                         busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid
);

  localparam int SELW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr_v;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rword_v;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_q;
  logic [DEPTH-1:0]                  row_hit;
  logic [DEPTH-1:0][SELW-1:0]        row_sel;

  assign wdata_v = wr_data;
  assign raddr_v = rd_addr;
  assign rd_data = rdata_q;
  assign busy    = (state_q == CLEAR);

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_ROW) state_d = IDLE;
        else                       clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  // ---------------- write path ----------------
  // Each row owns a matcher; an out-of-range address matches no row and is
  // therefore dropped without extra logic.
  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    regfile_wr_arb #(
      .NUM_WR     (NUM_WR),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SELW       (SELW)
    ) u_arb (
      .addr    (ADDR_WIDTH'(r)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .hit     (row_hit[r]),
      .sel     (row_sel[r])
    );
  end

  // Storage is not reset; the sequencer zeroes it. The IDLE cycle that
  // accepts clr_req still performs its writes.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (row_hit[r]) mem[r] <= wdata_v[row_sel[r]];
      end
    end
  end

  // ---------------- read path ----------------
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic            byp_hit;
    logic [SELW-1:0] byp_sel;
    logic            in_rng;

`ifdef REGFILE_BYPASS_EN
    regfile_wr_arb #(
      .NUM_WR     (NUM_WR),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SELW       (SELW)
    ) u_byp (
      .addr    (raddr_v[j]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .hit     (byp_hit),
      .sel     (byp_sel)
    );
`else
    assign byp_hit = 1'b0;
    assign byp_sel = '0;
`endif

    assign in_rng     = ({1'b0, raddr_v[j]} < DEPTH_W);
    assign rword_v[j] = !in_rng ? '0 :
                        byp_hit ? wdata_v[byp_sel] : mem[raddr_v[j]];
  end

  // Unrequested ports keep their last data; everything reads as zero
  // while the array is being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rd_valid <= '0;
    end else if (busy) begin
      rdata_q  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int j = 0; j < NUM_RD; j++) begin
        if (rd_en[j]) rdata_q[j] <= rword_v[j];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp.
// Reads push their expected word (from a bench-side array model) into a
// scoreboard queue when driven; the queue is drained and compared one cycle
// later. Inputs change on negedge, outputs are sampled 1 time unit after
// posedge. Honours REGFILE_BYPASS_EN for same-cycle read-after-write.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW  = 128;
  localparam int AW  = 7;
  localparam int DEP = 128;
  localparam int NR  = 3;
  localparam int NW  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_req = 1'b0;
  logic             busy;
  logic [NW-1:0]    wr_en = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NR-1:0]    rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEP), .NUM_RD (NR), .NUM_WR (NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  typedef struct {
    int       port;
    rf_word_t data;
  } exp_t;

  exp_t     sbq[$];
  rf_word_t model [DEP];
  int       errors = 0;
  int       checks = 0;

  task automatic chk(input string tag, input rf_word_t obs, input rf_word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < DEP; a++) model[a] = '0;
  endtask

  task automatic wr(input int p, input int a, input rf_word_t d);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_data[p*DW +: DW]   = d;
  endtask

  // Call after any wr() of the same cycle so forwarding can be predicted.
  task automatic rd(input int p, input int a);
    exp_t e;
    e.port = p;
    e.data = model[a];
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < NW; i++)
      if (wr_en[i] && wr_addr[i*AW +: AW] == AW'(a)) e.data = wr_data[i*DW +: DW];
`endif
    rd_en[p]            = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
    sbq.push_back(e);
  endtask

  task automatic tick();
    logic [NR-1:0] vm;
    exp_t          e;
    vm = '0;
    for (int k = 0; k < sbq.size(); k++) vm[sbq[k].port] = 1'b1;
    for (int i = 0; i < NW; i++)
      if (wr_en[i]) model[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
    @(posedge clk); #1;
    chk("rd_valid", rf_word_t'(rd_valid), rf_word_t'(vm));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("rd_data[%0d]", e.port), rd_data[e.port*DW +: DW], e.data);
    end
    @(negedge clk);
    wr_en = '0; rd_en = '0; clr_req = 1'b0;
  endtask

  // Counts posedges until busy drops; junk=1 drives writes/reads meanwhile
  // and checks that the read outputs stay zero.
  task automatic wait_busy_fall(input string tag, input int exp_n, input bit junk);
    int n;
    n = 0;
    if (junk) begin
      wr_en = '1; wr_data = '1; rd_en = '1;
      for (int i = 0; i < NW; i++) wr_addr[i*AW +: AW] = AW'(40);
      for (int j = 0; j < NR; j++) rd_addr[j*AW +: AW] = AW'(20);
    end
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (junk) begin
        chk("busy_rd_valid", rf_word_t'(rd_valid), '0);
        chk("busy_rd_data0", rd_data[0 +: DW], '0);
      end
      if (!busy) break;
    end
    chk(tag, rf_word_t'(n), rf_word_t'(exp_n));
    @(negedge clk);
    wr_en = '0; rd_en = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_model();

    // Reset: outputs quiet even with reads requested.
    rd_en = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", rf_word_t'(busy), rf_word_t'(1));
    chk("rst_rd_valid", rf_word_t'(rd_valid), '0);
    for (int j = 0; j < NR; j++) chk("rst_rd_data", rd_data[j*DW +: DW], '0);
    @(negedge clk);
    rd_en = '0;
    rst_n = 1'b1;
    wait_busy_fall("busy_cycles_init", DEP, 1'b0);

    rd(0, 5); tick();

    // Write then read on another port; then rd_data must hold.
    wr(0, 10, {16{8'hA5}}); tick();
    rd(2, 10); tick();
    tick();
    chk("rd_hold", rd_data[2*DW +: DW], {16{8'hA5}});

    // Write collision: port 1 wins.
    wr(0, 3, 128'h1); wr(1, 3, 128'h2); tick();
    rd(1, 3); tick();

    // Same-cycle write/read, then the later read.
    wr(0, 7, 128'hBEEF); rd(1, 7); tick();
    rd(0, 7); tick();

    // Same-cycle collision plus read of the collided address.
    wr(0, 9, 128'h1111); wr(1, 9, 128'h2222); rd(0, 9); tick();
    rd(2, 9); tick();

    // Top address and three concurrent reads.
    wr(1, DEP-1, {4{32'hC0FFEE01}}); tick();
    rd(0, 3); rd(1, 10); rd(2, DEP-1); tick();

    // Software clear: write 20, then clr_req with a write to 30 in the same cycle.
    wr(0, 20, 128'h55); tick();
    rd(0, 20); tick();
    clr_req = 1'b1; wr(1, 30, 128'h77); tick();
    clear_model();
    wait_busy_fall("busy_cycles_clr", DEP, 1'b1);
    rd(0, 20); rd(1, 30); rd(2, 40); tick();
    rd(0, 7); tick();

    // Reset during a clear restarts it.
    wr(0, 100, 128'hDEAD); tick();
    clr_req = 1'b1; rd(1, 100); tick();
    clear_model();
    repeat (60) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    rd_en = '1;
    #1;
    chk("midrst_busy", rf_word_t'(busy), rf_word_t'(1));
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_rd_valid", rf_word_t'(rd_valid), '0);
    for (int j = 0; j < NR; j++) chk("midrst_rd_data", rd_data[j*DW +: DW], '0);
    @(negedge clk);
    rd_en = '0;
    rst_n = 1'b1;
    wait_busy_fall("busy_cycles_rst", DEP, 1'b0);
    rd(0, 100); rd(2, 10); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
